// File: rtl/bingo_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bingo_game_ctrl_if
//  Purpose  : Bundles the keypad entry, inter-board link and display signals
//             of the bingo game controller.
//  Ports    : start_game, cur_number_BCD, enter_pulse     keypad side
//             inter_ready, interboard_en/_msg_type/_number link receive side
//             transmit, ctrl_en, ctrl_msg_type, ctrl_number link transmit side
//             map, circle, line_count, i_win, peer_win,
//             timeout_err                                display / status
//  Modports : master = controller, slave = surrounding logic / testbench
//  Revision : 1.0  initial release
// ============================================================================

`ifndef STATE_TURN
`define STATE_TURN 3'd1
`endif
`ifndef SEL_NUM
`define SEL_NUM 3'd2
`endif
`ifndef STATE_WIN
`define STATE_WIN 3'd3
`endif

interface bingo_game_ctrl_if #(
  parameter int N  = 5,
  parameter int NW = 7
);
  localparam int C = N * N;

  logic            start_game;
  logic [7:0]      cur_number_BCD;
  logic            enter_pulse;
  logic            inter_ready;
  logic            interboard_en;
  logic [2:0]      interboard_msg_type;
  logic [NW-1:0]   interboard_number;

  logic            transmit;
  logic            ctrl_en;
  logic [2:0]      ctrl_msg_type;
  logic [NW-1:0]   ctrl_number;
  logic [NW*C-1:0] map;
  logic [C-1:0]    circle;
  logic [4:0]      line_count;
  logic            i_win;
  logic            peer_win;
  logic            timeout_err;

  modport master (
    input  start_game, cur_number_BCD, enter_pulse, inter_ready,
           interboard_en, interboard_msg_type, interboard_number,
    output transmit, ctrl_en, ctrl_msg_type, ctrl_number, map, circle,
           line_count, i_win, peer_win, timeout_err
  );

  modport slave (
    output start_game, cur_number_BCD, enter_pulse, inter_ready,
           interboard_en, interboard_msg_type, interboard_number,
    input  transmit, ctrl_en, ctrl_msg_type, ctrl_number, map, circle,
           line_count, i_win, peer_win, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/bingo_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bingo_game_ctrl
//  Purpose  : N x N two-board bingo controller: number placement, guess and
//             peer-guess marking, line counting, win detection, peer-silence
//             timeout and the message exchange with the other board.
//  Ports    : clk             clock
//             rst             synchronous active-high reset
//             interboard_rst  synchronous active-high reset from the peer
//             bus             bingo_game_ctrl_if.master (keypad, link, display)
//  Revision : 1.0  initial release
// ============================================================================

module bingo_game_ctrl #(
  parameter int N            = 5,
  parameter int NW           = 7,
  parameter int LINES_TO_WIN = 1,
  parameter int IS_MASTER    = 1,
  parameter int TIMEOUT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  bingo_game_ctrl_if.master      bus
);

  localparam int          C   = N * N;
  localparam int          PW  = $clog2(C);
  localparam logic [31:0] C_U = C;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_START, S_SELECT, S_WAIT_PEER_SEL, S_SEND_READY, S_MY_TURN,
    S_CHECK, S_SEND_SEL, S_SEND_WIN, S_PEER_TURN, S_PEER_CHECK, S_FIN
  } state_e;

  state_e          state_q;
  logic [NW*C-1:0] map_q;
  logic [C-1:0]    circle_q;
  logic [PW-1:0]   idx_q;
  logic            en_q;
  logic [2:0]      type_q;
  logic [NW-1:0]   num_q;
  logic            i_win_q, peer_win_q, tmo_err_q;
  logic [31:0]     tcnt_q;

  // Keypad decode: two BCD digits to a binary cell number.
  logic [3:0]    key_hi, key_lo;
  logic [7:0]    key_val;
  logic          key_ok;
  logic [NW-1:0] key_num;
  assign key_hi  = bus.cur_number_BCD[7:4];
  assign key_lo  = bus.cur_number_BCD[3:0];
  assign key_val = ({4'd0, key_hi} * 8'd10) + {4'd0, key_lo};
  assign key_ok  = (key_hi <= 4'd9) && (key_lo <= 4'd9) && (key_val != 8'd0)
                   && ({24'd0, key_val} <= C_U);
  assign key_num = NW'(key_val);

  logic rx_ok;
  assign rx_ok = (bus.interboard_number != '0)
                 && (32'(bus.interboard_number) <= C_U);

  // Position lookup for the keypad number and the received number. Unplaced
  // cells hold 0, which never matches a valid number.
  logic          key_hit, rx_hit;
  logic [PW-1:0] key_pos, rx_pos;
  always_comb begin
    key_hit = 1'b0;
    key_pos = '0;
    rx_hit  = 1'b0;
    rx_pos  = '0;
    for (int p = 0; p < C; p++) begin
      if (map_q[NW*p +: NW] == key_num) begin
        key_hit = 1'b1;
        key_pos = PW'(p);
      end
      if (map_q[NW*p +: NW] == bus.interboard_number) begin
        rx_hit = 1'b1;
        rx_pos = PW'(p);
      end
    end
  end

  // Completed rows, columns and both diagonals.
  logic [4:0] lines;
  always_comb begin : p_lines
    logic f_row, f_col, f_d0, f_d1;
    lines = '0;
    f_row = 1'b1;
    f_col = 1'b1;
    f_d0  = 1'b1;
    f_d1  = 1'b1;
    for (int r = 0; r < N; r++) begin
      f_row = 1'b1;
      f_col = 1'b1;
      for (int c = 0; c < N; c++) begin
        f_row = f_row & circle_q[r*N + c];
        f_col = f_col & circle_q[c*N + r];
      end
      lines = lines + {4'd0, f_row} + {4'd0, f_col};
      f_d0  = f_d0 & circle_q[r*N + r];
      f_d1  = f_d1 & circle_q[r*N + (N-1-r)];
    end
    lines = lines + {4'd0, f_d0} + {4'd0, f_d1};
  end

  logic win, waiting, tmo_hit;
  assign win     = (lines >= 5'(LINES_TO_WIN));
  assign waiting = (state_q == S_WAIT_PEER_SEL) || (state_q == S_PEER_TURN);
  assign tmo_hit = (TIMEOUT != 0) && (tcnt_q == 32'(TIMEOUT - 1));

  // inter_ready is only honoured after the strobe cycle of a SEND state.
  logic sent;
  assign sent = !en_q && bus.inter_ready;

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q    <= S_IDLE;
      map_q      <= '0;
      circle_q   <= '0;
      idx_q      <= '0;
      en_q       <= 1'b0;
      type_q     <= '0;
      num_q      <= '0;
      i_win_q    <= 1'b0;
      peer_win_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      en_q <= 1'b0;
      // Every entry into a wait state comes from a non-wait state, so the
      // counter is already zero on entry.
      tcnt_q <= waiting ? tcnt_q + 32'd1 : '0;
      case (state_q)
        S_IDLE: begin
          if (IS_MASTER != 0) begin
            if (bus.start_game) begin
              state_q <= S_SEND_START;
              en_q    <= 1'b1;
              type_q  <= `STATE_TURN;
              num_q   <= '0;
            end
          end else if (bus.interboard_en &&
                       bus.interboard_msg_type == `STATE_TURN) begin
            state_q <= S_SELECT;
          end
        end
        S_SEND_START: if (sent) begin
          state_q <= S_SELECT;
          type_q  <= '0;
        end
        S_SELECT: if (bus.enter_pulse && key_ok && !key_hit) begin
          map_q[NW*idx_q +: NW] <= key_num;
          idx_q                 <= idx_q + 1'b1;
          if (idx_q == PW'(C - 1)) begin
            if (IS_MASTER != 0) begin
              state_q <= S_WAIT_PEER_SEL;
            end else begin
              state_q <= S_SEND_READY;
              en_q    <= 1'b1;
              type_q  <= `STATE_TURN;
              num_q   <= '0;
            end
          end
        end
        S_WAIT_PEER_SEL: begin
          if (bus.interboard_en && bus.interboard_msg_type == `STATE_TURN) begin
            state_q <= S_MY_TURN;
          end else if (tmo_hit) begin
            state_q   <= S_FIN;
            tmo_err_q <= 1'b1;
          end
        end
        S_SEND_READY: if (sent) begin
          state_q <= S_PEER_TURN;
          type_q  <= '0;
        end
        S_MY_TURN: if (bus.enter_pulse && key_ok && key_hit && !circle_q[key_pos]) begin
          circle_q[key_pos] <= 1'b1;
          num_q             <= key_num;
          state_q           <= S_CHECK;
        end
        S_CHECK: begin
          en_q <= 1'b1;
          if (win) begin
            state_q <= S_SEND_WIN;
            type_q  <= `STATE_WIN;
            num_q   <= '0;
          end else begin
            state_q <= S_SEND_SEL;
            type_q  <= `SEL_NUM;
          end
        end
        S_SEND_SEL: if (sent) begin
          state_q <= S_PEER_TURN;
          type_q  <= '0;
          num_q   <= '0;
        end
        S_SEND_WIN: if (sent) begin
          state_q <= S_FIN;
          type_q  <= '0;
          num_q   <= '0;
          i_win_q <= 1'b1;
        end
        S_PEER_TURN: begin
          if (bus.interboard_en && bus.interboard_msg_type == `SEL_NUM
              && rx_ok && rx_hit) begin
            circle_q[rx_pos] <= 1'b1;
            state_q          <= S_PEER_CHECK;
          end else if (bus.interboard_en && bus.interboard_msg_type == `STATE_WIN) begin
            state_q    <= S_FIN;
            peer_win_q <= 1'b1;
          end else if (tmo_hit) begin
            state_q   <= S_FIN;
            tmo_err_q <= 1'b1;
          end
        end
        S_PEER_CHECK: begin
          if (win) begin
            state_q <= S_SEND_WIN;
            en_q    <= 1'b1;
            type_q  <= `STATE_WIN;
            num_q   <= '0;
          end else begin
            state_q <= S_MY_TURN;
          end
        end
        S_FIN: if (bus.start_game) begin
          state_q    <= S_IDLE;
          map_q      <= '0;
          circle_q   <= '0;
          idx_q      <= '0;
          i_win_q    <= 1'b0;
          peer_win_q <= 1'b0;
          tmo_err_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.transmit      = (state_q == S_SEND_START) || (state_q == S_SEND_READY) ||
                             (state_q == S_SEND_SEL)   || (state_q == S_SEND_WIN);
  assign bus.ctrl_en       = en_q;
  assign bus.ctrl_msg_type = type_q;
  assign bus.ctrl_number   = num_q;
  assign bus.map           = map_q;
  assign bus.circle        = circle_q;
  assign bus.line_count    = lines;
  assign bus.i_win         = i_win_q;
  assign bus.peer_win      = peer_win_q;
  assign bus.timeout_err   = tmo_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bingo_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bingo_game_ctrl
//  Purpose  : Directed self-checking bench for bingo_game_ctrl: a 5x5 master
//             (two lines to win, 100-cycle timeout) and a 3x3 slave.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef STATE_TURN
`define STATE_TURN 3'd1
`endif
`ifndef SEL_NUM
`define SEL_NUM 3'd2
`endif
`ifndef STATE_WIN
`define STATE_WIN 3'd3
`endif

module tb_bingo_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irst_a = 1'b0;
  logic irst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bingo_game_ctrl_if #(.N(5), .NW(7)) ia ();
  bingo_game_ctrl_if #(.N(3), .NW(4)) ib ();

  bingo_game_ctrl #(.N(5), .NW(7), .LINES_TO_WIN(2), .IS_MASTER(1), .TIMEOUT(100)) dut_a (
    .clk(clk), .rst(rst), .interboard_rst(irst_a), .bus(ia.master)
  );

  bingo_game_ctrl #(.N(3), .NW(4), .LINES_TO_WIN(1), .IS_MASTER(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .interboard_rst(irst_b), .bus(ib.master)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    bcd = 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // ---------------- master (A) helpers ----------------
  task automatic a_enter(input logic [7:0] b);
    ia.cur_number_BCD = b;
    ia.enter_pulse    = 1'b1;
    tick();
    ia.enter_pulse    = 1'b0;
  endtask

  task automatic a_rx(input logic [2:0] t, input logic [6:0] n);
    ia.interboard_msg_type = t;
    ia.interboard_number   = n;
    ia.interboard_en       = 1'b1;
    tick();
    ia.interboard_en       = 1'b0;
  endtask

  task automatic a_ready();
    tick();
    ia.inter_ready = 1'b1;
    tick();
    ia.inter_ready = 1'b0;
  endtask

  task automatic a_place(input bit noisy);
    for (int v = 1; v <= 25; v++) begin
      a_enter(bcd(v));
      if (noisy && v == 7) begin
        a_enter(8'h07);
        a_enter(8'h30);
        a_enter(8'h0A);
        a_enter(8'h00);
      end
    end
  endtask

  task automatic a_guess(input int v);
    a_enter(bcd(v));
    tick();
    a_ready();
  endtask

  task automatic a_peer(input int v);
    a_rx(`SEL_NUM, 7'(v));
    tick();
  endtask

  // ---------------- slave (B) helpers ----------------
  task automatic b_enter(input logic [7:0] b);
    ib.cur_number_BCD = b;
    ib.enter_pulse    = 1'b1;
    tick();
    ib.enter_pulse    = 1'b0;
  endtask

  task automatic b_rx(input logic [2:0] t, input logic [3:0] n);
    ib.interboard_msg_type = t;
    ib.interboard_number   = n;
    ib.interboard_en       = 1'b1;
    tick();
    ib.interboard_en       = 1'b0;
  endtask

  logic [174:0] exp_a;
  logic [35:0]  exp_b;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 25; p++) exp_a[7*p +: 7] = 7'(p + 1);
    for (int p = 0; p < 9; p++)  exp_b[4*p +: 4] = 4'(p + 1);

    ia.start_game = 0; ia.cur_number_BCD = 0; ia.enter_pulse = 0; ia.inter_ready = 0;
    ia.interboard_en = 0; ia.interboard_msg_type = 0; ia.interboard_number = 0;
    ib.start_game = 0; ib.cur_number_BCD = 0; ib.enter_pulse = 0; ib.inter_ready = 0;
    ib.interboard_en = 0; ib.interboard_msg_type = 0; ib.interboard_number = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_map",    ia.map, '0);
    check("rst_circle", ia.circle, '0);
    check("rst_flags",  {ia.transmit, ia.ctrl_en, ia.ctrl_msg_type, ia.i_win, ia.peer_win, ia.timeout_err}, '0);
    check("rst_lines",  ia.line_count, '0);
    check("rst_b",      {ib.map, ib.transmit, ib.ctrl_en}, '0);

    // ---------------- slave N=3 ----------------
    ib.start_game = 1'b1; tick(); ib.start_game = 1'b0;
    check("b_start_ignored", {ib.transmit, ib.ctrl_en}, 2'b00);
    b_rx(`STATE_TURN, 4'd0);
    for (int v = 1; v <= 8; v++) begin
      b_enter(bcd(v));
      if (v == 5) begin
        b_enter(8'h05);
        b_enter(8'h10);
      end
    end
    check("b_not_done", ib.ctrl_en, 1'b0);
    b_enter(bcd(9));
    check("b_ready_en",   {ib.ctrl_en, ib.transmit, ib.ctrl_msg_type}, {2'b11, `STATE_TURN});
    check("b_map",        ib.map, exp_b);
    tick();
    check("b_en_onecyc",  {ib.ctrl_en, ib.transmit}, 2'b01);
    ib.inter_ready = 1'b1; tick(); ib.inter_ready = 1'b0;
    check("b_peer_turn",  {ib.transmit, ib.ctrl_msg_type}, '0);
    b_rx(`SEL_NUM, 4'd12);
    check("b_bad_rx",     ib.circle, '0);
    b_rx(`STATE_WIN, 4'd0);
    check("b_peer_win",   {ib.peer_win, ib.i_win, ib.transmit}, 3'b100);

    // ---------------- master N=5 placement ----------------
    ia.start_game = 1'b1; tick(); ia.start_game = 1'b0;
    check("a_start_send", {ia.ctrl_en, ia.transmit, ia.ctrl_msg_type}, {2'b11, `STATE_TURN});
    a_ready();
    check("a_select",     {ia.transmit, ia.ctrl_msg_type}, '0);
    a_place(1'b1);
    check("a_map",        ia.map, exp_a);
    a_enter(bcd(3));
    check("a_wait_noenter", ia.circle, '0);

    // ---------------- guess latency ----------------
    a_rx(`STATE_TURN, 7'd0);
    a_enter(bcd(3));
    check("a_guess_circle", {ia.circle[2], ia.ctrl_en}, 2'b10);
    tick();
    check("a_guess_send", {ia.ctrl_en, ia.ctrl_msg_type, ia.ctrl_number}, {1'b1, `SEL_NUM, 7'd3});
    a_ready();

    // ---------------- peer mark latency ----------------
    a_rx(`SEL_NUM, 7'd10);
    check("a_peer_mark", ia.circle[9], 1'b1);
    tick();
    a_enter(bcd(3));
    tick();
    check("a_dup_guess", {ia.transmit, ia.ctrl_en}, 2'b00);

    // ---------------- two-line win ----------------
    a_guess(1);  a_peer(15);
    a_guess(2);  a_peer(20);
    a_guess(4);  a_peer(7);
    a_enter(bcd(5));
    check("a_lines_1", ia.line_count, 5'd1);
    tick();
    check("a_no_win_yet", {ia.ctrl_en, ia.ctrl_msg_type}, {1'b1, `SEL_NUM});
    a_ready();
    a_rx(`SEL_NUM, 7'd25);
    check("a_lines_2", ia.line_count, 5'd2);
    tick();
    check("a_send_win", {ia.ctrl_en, ia.ctrl_msg_type, ia.i_win}, {1'b1, `STATE_WIN, 1'b0});
    a_ready();
    check("a_fin_win", {ia.i_win, ia.peer_win, ia.timeout_err, ia.transmit}, 4'b1000);

    // ---------------- restart clears ----------------
    ia.start_game = 1'b1; tick(); ia.start_game = 1'b0;
    check("a_restart", {ia.map, ia.circle, ia.i_win, ia.line_count}, '0);

    // ---------------- timeout in PEER_TURN ----------------
    ia.start_game = 1'b1; tick(); ia.start_game = 1'b0;
    a_ready();
    a_place(1'b0);
    a_rx(`STATE_TURN, 7'd0);
    a_guess(1);
    repeat (99) tick();
    check("a_tmo_early", ia.timeout_err, 1'b0);
    tick();
    check("a_tmo_fire",  ia.timeout_err, 1'b1);
    ia.start_game = 1'b1; tick(); ia.start_game = 1'b0;
    check("a_tmo_clear", {ia.timeout_err, ia.map}, '0);

    // ---------------- peer reset during CHECK ----------------
    ia.start_game = 1'b1; tick(); ia.start_game = 1'b0;
    a_ready();
    a_place(1'b0);
    a_rx(`STATE_TURN, 7'd0);
    a_enter(bcd(3));
    check("a_in_check", ia.circle[2], 1'b1);
    irst_a = 1'b1; tick(); irst_a = 1'b0;
    check("a_irst", {ia.circle, ia.map, ia.ctrl_en, ia.transmit}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
